// File: rtl/bmp_stream_loader.sv
// BMP byte-stream parser: decodes and validates the file header, then writes
// RGB888 pixels (24/32 bpp, bottom-up or top-down) to a framebuffer port.
module bmp_stream_loader #(
    parameter int H_MAX      = 640,
    parameter int V_MAX      = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int DIM_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [23:0]           fb_data,
    output logic [DIM_WIDTH-1:0]  img_width,
    output logic [DIM_WIDTH-1:0]  img_height,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [3:0]            err_code,
    output logic [3:0]            status
);

    localparam int CNT_W = $clog2(H_MAX * 4 + 1);
    localparam int ROW_W = $clog2(V_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_SEEK   = 3'd2;
    localparam logic [2:0] S_PIXELS = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic signed [31:0] H_MAX_S = H_MAX;
    localparam logic [31:0]        V_MAX_U = V_MAX;
    localparam logic [ADDR_WIDTH-1:0] H_STEP = ADDR_WIDTH'(H_MAX);

    logic [2:0]             state;
    logic [31:0]            bcnt;
    logic [7:0]             magic_lo;
    logic [31:0]            offset;
    logic signed [31:0]     width_raw;
    logic signed [31:0]     height_raw;
    logic [15:0]            bpp;
    logic [31:0]            compression;

    logic                   is32;
    logic                   top_down;
    logic [CNT_W-1:0]       last_col;
    logic [ROW_W-1:0]       last_row;
    logic [CNT_W-1:0]       pad_len;

    logic [1:0]             byte_sel;
    logic [7:0]             b_byte;
    logic [7:0]             g_byte;
    logic [CNT_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic                   in_pad;
    logic [CNT_W-1:0]       pad_cnt;
    logic [ADDR_WIDTH-1:0]  row_base;

    logic                   consume;
    logic [1:0]             lane;
    logic [31:0]            abs_h;
    logic                   size_bad;
    logic [3:0]             chk_code;
    logic                   in_pixels;
    logic                   px_last_byte;
    logic                   row_end;

    // Header fields at 10, 18, 22 and 30 all start on a byte offset of 2 mod 4.
    assign lane    = bcnt[1:0] - 2'd2;
    assign consume = in_valid && (state == S_HEADER || state == S_SEEK || state == S_PIXELS);
    assign abs_h   = height_raw[31] ? $unsigned(-height_raw) : $unsigned(height_raw);

    assign size_bad = (width_raw < 32'sd1) || (width_raw > H_MAX_S) ||
                      (abs_h == 32'd0) || (abs_h > V_MAX_U);

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        chk_code = 4'd0;
        if ((bpp != 16'd24 && bpp != 16'd32) || compression != 32'd0)
            chk_code = 4'd2;
        else if (size_bad)
            chk_code = 4'd3;
        else if (offset < 32'd54)
            chk_code = 4'd4;
    end

    assign in_pixels    = consume && (state == S_PIXELS);
    assign px_last_byte = !in_pad && (is32 ? (byte_sel == 2'd3) : (byte_sel == 2'd2));
    assign row_end      = (in_pixels && px_last_byte && col == last_col && pad_len == '0) ||
                          (in_pixels && in_pad && pad_cnt == CNT_W'(1));

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            state       <= (start && !rst) ? S_HEADER : S_IDLE;
            bcnt        <= '0;
            magic_lo    <= '0;
            offset      <= '0;
            width_raw   <= '0;
            height_raw  <= '0;
            bpp         <= '0;
            compression <= '0;
            is32        <= 1'b0;
            top_down    <= 1'b0;
            last_col    <= '0;
            last_row    <= '0;
            pad_len     <= '0;
            byte_sel    <= '0;
            b_byte      <= '0;
            g_byte      <= '0;
            col         <= '0;
            row         <= '0;
            in_pad      <= 1'b0;
            pad_cnt     <= '0;
            row_base    <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            img_width   <= '0;
            img_height  <= '0;
            err_code    <= '0;
        end else begin
            fb_we <= 1'b0;
            if (consume)
                bcnt <= bcnt + 32'd1;

            case (state)
                S_HEADER: if (consume) begin
                    if (bcnt == 32'd0)
                        magic_lo <= in_byte;
                    if (bcnt == 32'd1 && {magic_lo, in_byte} != 16'h424D) begin
                        state    <= S_ERR;
                        err_code <= 4'd1;
                    end
                    if (bcnt >= 32'd10 && bcnt <= 32'd13)
                        offset[{lane, 3'b000} +: 8] <= in_byte;
                    if (bcnt >= 32'd18 && bcnt <= 32'd21)
                        width_raw[{lane, 3'b000} +: 8] <= in_byte;
                    if (bcnt >= 32'd22 && bcnt <= 32'd25)
                        height_raw[{lane, 3'b000} +: 8] <= in_byte;
                    if (bcnt >= 32'd28 && bcnt <= 32'd29)
                        bpp[{bcnt[0], 3'b000} +: 8] <= in_byte;
                    if (bcnt >= 32'd30 && bcnt <= 32'd33)
                        compression[{lane, 3'b000} +: 8] <= in_byte;

                    if (bcnt == 32'd53) begin
                        img_width  <= DIM_WIDTH'(width_raw);
                        img_height <= DIM_WIDTH'(abs_h);
                        is32       <= (bpp == 16'd32);
                        top_down   <= height_raw[31];
                        last_col   <= CNT_W'(width_raw - 32'sd1);
                        last_row   <= ROW_W'(abs_h - 32'd1);
                        // 24 bpp rows carry width mod 4 pad bytes; 32 bpp rows never pad.
                        pad_len    <= (bpp == 16'd32) ? '0 : CNT_W'(width_raw[1:0]);
                        row_base   <= height_raw[31] ? '0
                                      : ADDR_WIDTH'((abs_h - 32'd1) * 32'(H_MAX));
                        if (chk_code != 4'd0) begin
                            state    <= S_ERR;
                            err_code <= chk_code;
                        end else if (offset == 32'd54) begin
                            state <= S_PIXELS;
                        end else begin
                            state <= S_SEEK;
                        end
                    end
                end

                S_SEEK: if (consume && bcnt == offset - 32'd1)
                    state <= S_PIXELS;

                S_PIXELS: if (consume) begin
                    if (in_pad) begin
                        if (pad_cnt == CNT_W'(1))
                            in_pad <= 1'b0;
                        else
                            pad_cnt <= pad_cnt - CNT_W'(1);
                    end else begin
                        case (byte_sel)
                            2'd0: b_byte <= in_byte;
                            2'd1: g_byte <= in_byte;
                            2'd2: begin
                                fb_we   <= 1'b1;
                                fb_addr <= row_base + ADDR_WIDTH'(col);
                                fb_data <= {in_byte, g_byte, b_byte};
                            end
                            default: ;
                        endcase
                        byte_sel <= px_last_byte ? 2'd0 : byte_sel + 2'd1;
                        if (px_last_byte) begin
                            if (col == last_col) begin
                                col <= '0;
                                if (pad_len != '0) begin
                                    in_pad  <= 1'b1;
                                    pad_cnt <= pad_len;
                                end
                            end else begin
                                col <= col + CNT_W'(1);
                            end
                        end
                    end

                    if (row_end) begin
                        if (row == last_row) begin
                            state <= S_DONE;
                        end else begin
                            row      <= row + ROW_W'(1);
                            row_base <= top_down ? row_base + H_STEP : row_base - H_STEP;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    always_comb begin
        case (state)
            S_HEADER: status = 4'd1;
            S_SEEK:   status = 4'd2;
            S_PIXELS: status = 4'd3;
            S_DONE:   status = 4'd4;
            S_ERR:    status = 4'hE;
            default:  status = 4'd0;
        endcase
    end

    assign busy  = (state == S_HEADER) || (state == S_SEEK) || (state == S_PIXELS);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

endmodule

// File: tb/tb_bmp_stream_loader.sv
// Randomized bench for bmp_stream_loader: builds BMP streams, predicts the
// framebuffer writes from the file-format rules and compares every write.
module tb_bmp_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [23:0] fb_data;
    logic [11:0] img_width;
    logic [11:0] img_height;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  err_code;
    logic [3:0]  status;

    bmp_stream_loader #(
        .H_MAX(640), .V_MAX(480), .ADDR_WIDTH(19), .DIM_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .img_width(img_width), .img_height(img_height),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .status(status)
    );

    always #5 clk = ~clk;

    bit [7:0] stream[$];
    int exp_addr[$], exp_data[$], exp_lat[$];
    int got_addr[$], got_data[$], got_lat[$];
    int exp_code, exp_end, exp_w, exp_h;
    int sent;
    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            got_addr.push_back(int'(fb_addr));
            got_data.push_back(int'(fb_data));
            got_lat.push_back(sent);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int le32(int idx);
        return {stream[idx+3], stream[idx+2], stream[idx+1], stream[idx]};
    endfunction

    // Builds a BMP stream; maxlen truncates it (0 means complete plus trailing junk).
    function automatic void gen(int w, int h, int bpp, int off, bit [7:0] m1, int comp, int maxlen);
        bit [7:0] hdr[54];
        int ah, bypp, len;
        for (int i = 0; i < 54; i++) hdr[i] = 8'($urandom_range(0, 255));
        hdr[0] = 8'h42;
        hdr[1] = m1;
        for (int k = 0; k < 4; k++) begin
            hdr[10+k] = 8'(off >> (8*k));
            hdr[18+k] = 8'(w >> (8*k));
            hdr[22+k] = 8'(h >> (8*k));
            hdr[30+k] = 8'(comp >> (8*k));
        end
        hdr[28] = 8'(bpp);
        hdr[29] = 8'(bpp >> 8);
        stream.delete();
        for (int i = 0; i < 54; i++) stream.push_back(hdr[i]);
        for (int i = 54; i < off; i++) stream.push_back(8'($urandom_range(0, 255)));
        ah   = (h < 0) ? -h : h;
        bypp = bpp / 8;
        if (w >= 1 && w <= 640 && ah >= 1 && ah <= 480 && bypp > 0)
            len = ((w * bypp + 3) / 4) * 4 * ah + 6;
        else
            len = 16;
        for (int i = 0; i < len; i++) begin
            if (maxlen > 0 && stream.size() >= maxlen) break;
            stream.push_back(8'($urandom_range(0, 255)));
        end
    endfunction

    // Reference: decode the header by the BMP rules and list every expected write.
    function automatic void model(int limit);
        int off, w, h, ah, bpp, comp, bypp, stride, base, drow;
        exp_addr.delete(); exp_data.delete(); exp_lat.delete();
        off  = le32(10);
        w    = le32(18);
        h    = le32(22);
        comp = le32(30);
        bpp  = {stream[29], stream[28]};
        ah   = (h < 0) ? -h : h;
        exp_w = w;
        exp_h = ah;
        if (stream[0] != 8'h42 || stream[1] != 8'h4D)           exp_code = 1;
        else if ((bpp != 24 && bpp != 32) || comp != 0)        exp_code = 2;
        else if (w < 1 || w > 640 || ah < 1 || ah > 480)       exp_code = 3;
        else if (off < 54)                                     exp_code = 4;
        else                                                   exp_code = 0;
        if (exp_code == 1) begin exp_end = 1; return; end
        if (exp_code != 0) begin exp_end = 53; return; end
        bypp    = bpp / 8;
        stride  = ((w * bypp + 3) / 4) * 4;
        exp_end = off + stride * ah - 1;
        for (int r = 0; r < ah; r++) begin
            for (int c = 0; c < w; c++) begin
                base = off + r * stride + c * bypp;
                if (base + 2 >= limit || base + 2 >= stream.size()) return;
                drow = (h > 0) ? (ah - 1 - r) : r;
                exp_addr.push_back(drow * 640 + c);
                exp_data.push_back({stream[base+2], stream[base+1], stream[base]});
                exp_lat.push_back(base + 3);
            end
        end
    endfunction

    task automatic pulse_start();
        got_addr.delete(); got_data.delete(); got_lat.delete();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sent  = 0;
    endtask

    task automatic feed(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_byte  = stream[i];
            @(posedge clk); #1;
            sent     = i + 1;
            in_valid = 1'b0;
            if (i == exp_end - 1) begin
                @(negedge clk);
                check({name, " not_final_early"}, {done, error}, 2'b00);
            end
            if (i == exp_end) begin
                @(negedge clk);
                check({name, " final_timing"}, {done, error}, (exp_code == 0) ? 2'b10 : 2'b01);
            end
        end
    endtask

    task automatic compare_writes(input string name);
        check({name, " n_writes"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s data[%0d]", name, i), got_data[i], exp_data[i]);
            check($sformatf("%s lat[%0d]", name, i), got_lat[i], exp_lat[i]);
        end
    endtask

    task automatic run_test(input string name);
        model(stream.size());
        pulse_start();
        @(negedge clk);
        check({name, " status_hdr"}, status, 4'd1);
        feed(name, stream.size());
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_writes(name);
        check({name, " status"}, status, (exp_code == 0) ? 4'd4 : 4'hE);
        check({name, " err_code"}, err_code, exp_code);
        check({name, " busy"}, busy, 1'b0);
        if (exp_code == 0) begin
            check({name, " img_width"}, img_width, exp_w);
            check({name, " img_height"}, img_height, exp_h);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; sent = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst status", status, 4'd0);
        check("rst outputs", {fb_we, busy, done, error, err_code}, 8'h00);
        check("rst dims", {img_width, img_height}, 24'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        gen(2, 2, 24, 54, 8'h4D, 0, 0);   run_test("bu2x2");
        gen(2, -2, 24, 54, 8'h4D, 0, 0);  run_test("td2x2");

        gen(1, 1, 32, 54, 8'h4D, 0, 0);
        stream[54] = 8'h11; stream[55] = 8'h22; stream[56] = 8'h33; stream[57] = 8'hFF;
        run_test("p32");
        if (got_data.size() > 0) check("p32 literal_data", got_data[0], 24'h332211);

        gen(1, 1, 24, 138, 8'h4D, 0, 0);  run_test("off138");

        gen(2, 2, 24, 54, 8'h4E, 0, 0);   run_test("err_magic");
        gen(641, 1, 24, 54, 8'h4D, 0, 0); run_test("err_width");
        gen(2, 2, 16, 54, 8'h4D, 0, 0);   run_test("err_bpp");
        gen(2, 2, 24, 40, 8'h4D, 0, 0);   run_test("err_off");
        gen(2, 2, 24, 54, 8'h4D, 1, 0);   run_test("err_comp");

        for (int t = 0; t < 6; t++) begin
            int w, h, bpp, off;
            w   = $urandom_range(1, 9);
            h   = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1) h = -h;
            bpp = ($urandom_range(0, 1) == 1) ? 32 : 24;
            off = 54 + $urandom_range(0, 24);
            gen(w, h, bpp, off, 8'h4D, 0, 0);
            run_test($sformatf("rnd%0d", t));
        end

        // Abort a 640x480 load on the R byte of row 1, pixel 10 (stream index 2006).
        gen(640, 480, 24, 54, 8'h4D, 0, 2007);
        model(2006);
        pulse_start();
        feed("abort", 2006);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_byte  = stream[2006];
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort status", status, 4'd0);
        check("abort fb_we", fb_we, 1'b0);
        check("abort busy", busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_byte  = 8'h42;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_writes("abort");
        check("idle_ignores status", status, 4'd0);

        gen(640, 2, 24, 54, 8'h4D, 0, 0);  run_test("reload640");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
